// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with a per-register busy scoreboard.
//
// Reads are combinational, with same-cycle write-to-read bypass. There is one
// clocked write-back port. The scoreboard marks a register busy when an
// instruction issues it as a destination. The bit clears when that register
// is written back. If an issue and a write-back hit the same register in the
// same cycle, the issue wins.
//
// Optional build macro: REGFILE_ZERO_REG_EN. When it is defined, register 0
// is hardwired to zero: writes are dropped, it never becomes busy, and it
// reads 0 even on the bypass path.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   wr_en/addr/data   write-back port; also clears the busy bit
//   iss_en/iss_addr   issue port; sets the busy bit
//   rd_addr           NUM_RD packed read addresses, port p at [p*AW +: AW]
//   rd_data           NUM_RD packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_busy           per-port busy flag, after the bypass rule
//   busy_cnt          registered popcount of the busy bits
//   all_idle          busy_cnt == 0

// One read port: bypass mux, array mux and busy lookup.
module reg_file_sb_rd_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic [AW-1:0]                rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
    input  logic [DEPTH-1:0]             busy,
    input  logic                         byp_en,
    input  logic [AW-1:0]                byp_addr,
    input  logic [WIDTH-1:0]             byp_data,
    input  logic                         blank,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_busy
);
    logic byp_hit;

    assign byp_hit = byp_en && (byp_addr == rd_addr);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        // Hold outputs at zero while reset is asserted. Otherwise a write
        // presented during reset would leak through the bypass path.
        if (!blank) begin
            rd_data = byp_hit ? byp_data : regs[rd_addr];
            rd_busy = busy[rd_addr] && !byp_hit;
        end
    end
endmodule

module reg_file_sb #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 16,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    output logic [AW:0]             busy_cnt,
    output logic                    all_idle
);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [AW:0]                 busy_cnt_q, busy_cnt_d;

    // Effective strobes. A hardwired register 0 is invisible to both ports.
    logic wr_eff, iss_eff, cnt_inc, cnt_dec;

    assign wr_eff  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
    assign iss_eff = iss_en && !(ZERO_REG && (iss_addr == '0));

    // The count moves only on real 0->1 and 1->0 transitions. This keeps it
    // equal to popcount(busy) without a full adder tree. A write-back to the
    // register being issued this cycle never decrements.
    assign cnt_inc = iss_eff && !busy_q[iss_addr];
    assign cnt_dec = wr_eff && busy_q[wr_addr] &&
                     !(iss_eff && (iss_addr == wr_addr));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_eff) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // Applied after the clear so that the issue wins a collision.
        if (iss_eff) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            reg_file_sb_rd_port #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_rd (
                .rd_addr  (rd_addr[p*AW +: AW]),
                .regs     (regs_q),
                .busy     (busy_q),
                .byp_en   (wr_eff),
                .byp_addr (wr_addr),
                .byp_data (wr_data),
                .blank    (rst),
                .rd_data  (rd_data[p*WIDTH +: WIDTH]),
                .rd_busy  (rd_busy[p])
            );
        end
    endgenerate

    assign busy_cnt = busy_cnt_q;
    assign all_idle = (busy_cnt_q == '0);
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the WISC-F18 datapath.
- Multiple combinational read ports; one clocked write port with same-cycle write-to-read bypass.
- Per-register busy scoreboard: set when an instruction issues a destination, cleared when it writes back.
- Replaces the per-bit cell/tristate-bitline array with a multiplexed array and adds hazard tracking.

Parameters:
- WIDTH, 16, data bits per register
- DEPTH, 16, number of registers, power of 2, min 2
- NUM_RD, 2, number of read ports, 1..4
- AW, $clog2(DEPTH), address width, derived only, never overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back register index
- wr_data  in  WIDTH  write-back data
- iss_en  in  1  issue strobe; marks destination busy
- iss_addr  in  AW  issued destination index
- rd_addr  in  NUM_RD*AW  packed read addresses; port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  packed read data; port p at [p*WIDTH +: WIDTH]
- rd_busy  out  NUM_RD  per-port: addressed register is busy (after bypass rule)
- busy_cnt  out  AW+1  number of registers currently busy
- all_idle  out  1  high when busy_cnt == 0

Behaviour:
- Reset (rst=1, async): all registers = 0, all busy bits = 0, busy_cnt = 0, all_idle = 1. Every rd_data reads 0 while rst is held.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
- Read: combinational, zero latency.
  - rd_data[p] = wr_data if wr_en && wr_addr == rd_addr[p] (bypass); otherwise reg[rd_addr[p]].
  - All ports are independent; any number of ports may share an address.
- Scoreboard update on the rising edge:
  - busy[iss_addr] <= 1 if iss_en.
  - busy[wr_addr] <= 0 if wr_en, unless iss_en && iss_addr == wr_addr. Issue wins: the new producer keeps the register busy.
  - wr_en to a non-busy register is legal: the data is written and busy stays 0.
  - iss_en to an already-busy register is legal: it stays 1 with no count change (WAW is permitted).
- rd_busy[p]:
  - = busy[rd_addr[p]] && !(wr_en && wr_addr == rd_addr[p]). Bypassed data is valid, so the port is not busy.
  - An issue in the same cycle does not affect rd_busy until the next cycle.
- busy_cnt:
  - Registered; always equals the popcount of busy.
  - Next value = current + (issue sets a 0 bit) - (write-back clears a 1 bit).
  - Range 0..DEPTH; never wraps. Width AW+1 holds DEPTH exactly.
- all_idle = (busy_cnt == 0), combinational from the register.
- Reset asserted mid-operation: state clears immediately regardless of clk. The first edge after deassertion behaves normally.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired: reads return 0, including on the bypass path.
  - Writes to 0 are discarded, and iss_en with iss_addr == 0 never sets busy.
  - rd_busy for address 0 is always 0; the max busy_cnt is DEPTH-1.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read: assert rst mid-cycle with reg 3 = 0xBEEF; all rd_data = 0x0000, busy_cnt = 0 and all_idle = 1 immediately, with no clock edge needed.
- Write/read and bypass: wr_en, wr_addr=5, wr_data=0x1234, rd_addr port0=5 in the same cycle -> rd_data port0 = 0x1234 before the edge; port1 reading 5 after the edge = 0x1234.
- Scoreboard lifecycle: issue reg 7 -> next cycle rd_busy=1, busy_cnt=1, all_idle=0. Write-back reg 7 with 0x00AA -> rd_busy=0 in that cycle via bypass, busy_cnt=0 after the edge.
- Issue/write-back collision: reg 9 busy; iss_en and wr_en both to 9 in the same cycle -> data written, busy stays 1, busy_cnt unchanged at 1.
- Fill and drain: issue all 16 registers over 16 cycles -> busy_cnt = 16 (15 with REGFILE_ZERO_REG_EN). Write back all -> busy_cnt = 0. Write-back to an idle register leaves the count unchanged.
- Zero register (macro defined): write 0xFFFF to reg 0 and issue reg 0 -> rd_data = 0x0000, rd_busy = 0 and busy_cnt = 0 for reg 0, including during the write cycle.
